// File: rtl/dbf_ch_dyn.sv
// Single receive channel for a digital beamformer with dynamic focusing.
// The ring buffer supplies the coarse delay. A per-sample LUT holds the
// focusing delay. The delayed sample is then apodised with round/saturate.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   tx_en, start                sample gating (accept when 0), line start
//   ch_in                       signed input sample
//   apo_din, apo_we             apodisation coefficient load
//   lut_addr, lut_din, lut_we   focusing delay LUT write port
//   dbf_dout, dbf_dout_valid    apodised delayed sample
//   cd_dout, cd_dout_valid      coarse-delayed sample (debug tap)
//   busy, line_done, lut_wr_err line status
module dbf_ch_dyn #(
    parameter int INPUT_WD = 14,
    parameter int APO_WD   = 16,
    parameter int APO_FRAC = 15,
    parameter int ADDR_WD  = 10,
    parameter int DLY_WD   = 7,
    parameter int OUT_WD   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tx_en,
    input  logic                       start,
    input  logic signed [INPUT_WD-1:0] ch_in,
    input  logic signed [APO_WD-1:0]   apo_din,
    input  logic                       apo_we,
    input  logic [ADDR_WD-1:0]         lut_addr,
    input  logic [DLY_WD-1:0]          lut_din,
    input  logic                       lut_we,
    output logic signed [OUT_WD-1:0]   dbf_dout,
    output logic                       dbf_dout_valid,
    output logic signed [INPUT_WD-1:0] cd_dout,
    output logic                       cd_dout_valid,
    output logic                       busy,
    output logic                       line_done,
    output logic                       lut_wr_err
);

    localparam int PW = INPUT_WD + APO_WD;
    localparam int RW = PW + 1 - APO_FRAC;
    localparam logic signed [PW:0] HALF = (PW+1)'(1) << (APO_FRAC - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state_q;
    logic [DLY_WD-1:0]          wr_ptr_q;
    logic [DLY_WD-1:0]          fill_q;
    logic [ADDR_WD-1:0]         idx_q;
    logic signed [APO_WD-1:0]   coef_q;
    logic signed [INPUT_WD-1:0] cd_q;
    logic                       cd_v_q;
    logic signed [PW-1:0]       prod_q;
    logic                       prod_v_q;
    logic signed [OUT_WD-1:0]   dout_q;
    logic                       dout_v_q;
    logic                       done_q;
    logic                       err_q;

    logic [DLY_WD-1:0]   lut_q  [2**ADDR_WD];
    logic [INPUT_WD-1:0] ring_q [2**DLY_WD];

    logic                       accept;
    logic                       in_line;
    logic [ADDR_WD-1:0]         idx_d;
    logic [DLY_WD-1:0]          dly;
    logic [DLY_WD-1:0]          rd_addr;
    logic signed [INPUT_WD-1:0] cd_d;
    logic signed [PW:0]         rnd_sum;
    logic signed [RW-1:0]       r;
    logic signed [OUT_WD-1:0]   r_out;

    // A sample arriving with start is the first sample of the new line.
    assign accept  = !tx_en;
    assign in_line = (state_q == RUN) || start;
    assign idx_d   = start ? '0 : idx_q;
    assign dly     = lut_q[idx_d];
    assign rd_addr = wr_ptr_q - dly;

    always_comb begin
        cd_d = '0;
        if (dly == '0) begin
            cd_d = ch_in;
        end else if (dly <= fill_q) begin
            cd_d = ring_q[rd_addr];
        end
    end

    // Round half toward +inf, then drop the fraction bits.
    assign rnd_sum = {prod_q[PW-1], prod_q} + HALF;
    assign r       = RW'(rnd_sum >>> APO_FRAC);

    generate
        if (RW <= OUT_WD) begin : g_ext
            assign r_out = OUT_WD'(r);
        end else begin : g_sat
            localparam logic signed [RW-1:0] MAXV =
                {{(RW-OUT_WD+1){1'b0}}, {(OUT_WD-1){1'b1}}};
            localparam logic signed [RW-1:0] MINV =
                {{(RW-OUT_WD+1){1'b1}}, {(OUT_WD-1){1'b0}}};
            always_comb begin
                r_out = OUT_WD'(r);
                if (r > MAXV) begin
                    r_out = OUT_WD'(MAXV);
                end else if (r < MINV) begin
                    r_out = OUT_WD'(MINV);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            ring_q[wr_ptr_q] <= ch_in;
        end
        if (rst_n && lut_we && (state_q == IDLE)) begin
            lut_q[lut_addr] <= lut_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            idx_q    <= '0;
            coef_q   <= '0;
            cd_q     <= '0;
            cd_v_q   <= 1'b0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            dout_q   <= '0;
            dout_v_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= lut_we && (state_q == RUN);
            if (apo_we) begin
                coef_q <= apo_din;
            end
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (fill_q != '1) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
            cd_v_q <= accept && in_line;
            if (accept && in_line) begin
                cd_q <= cd_d;
            end
            prod_v_q <= cd_v_q;
            if (cd_v_q) begin
                prod_q <= PW'(cd_q) * PW'(coef_q);
            end
            dout_v_q <= prod_v_q;
            if (prod_v_q) begin
                dout_q <= r_out;
            end
            if (in_line) begin
                if (accept) begin
                    if (idx_d == '1) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        idx_q   <= idx_d + 1'b1;
                    end
                end else if (start) begin
                    state_q <= RUN;
                    idx_q   <= '0;
                end
            end
        end
    end

    assign dbf_dout       = dout_q;
    assign dbf_dout_valid = dout_v_q;
    assign cd_dout        = cd_q;
    assign cd_dout_valid  = cd_v_q;
    assign busy           = (state_q == RUN);
    assign line_done      = done_q;
    assign lut_wr_err     = err_q;

endmodule

// File: tb/tb_dbf_ch_dyn.sv
// Directed self-checking bench for dbf_ch_dyn (line length 16).
// Drives a linear sequence of steps and checks with immediate assertions.
module tb_dbf_ch_dyn;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               tx_en;
    logic               start;
    logic signed [13:0] ch_in;
    logic signed [15:0] apo_din;
    logic               apo_we;
    logic [3:0]         lut_addr;
    logic [6:0]         lut_din;
    logic               lut_we;
    logic signed [31:0] dbf_dout;
    logic               dbf_dout_valid;
    logic signed [13:0] cd_dout;
    logic               cd_dout_valid;
    logic               busy;
    logic               line_done;
    logic               lut_wr_err;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;

    dbf_ch_dyn #(.ADDR_WD(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tx_en(tx_en),
        .start(start),
        .ch_in(ch_in),
        .apo_din(apo_din),
        .apo_we(apo_we),
        .lut_addr(lut_addr),
        .lut_din(lut_din),
        .lut_we(lut_we),
        .dbf_dout(dbf_dout),
        .dbf_dout_valid(dbf_dout_valid),
        .cd_dout(cd_dout),
        .cd_dout_valid(cd_dout_valid),
        .busy(busy),
        .line_done(line_done),
        .lut_wr_err(lut_wr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (dbf_dout_valid) vcnt++;
    endtask

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int v, input bit st);
        ch_in = 14'(v);
        tx_en = 1'b0;
        start = st;
        tick();
        start = 1'b0;
        tx_en = 1'b1;
    endtask

    task automatic idle(input int n);
        tx_en = 1'b1;
        repeat (n) tick();
    endtask

    task automatic lut_set(input int val, input bit ramp);
        tx_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lut_addr = 4'(i);
            lut_din  = ramp ? 7'(i) : 7'(val);
            lut_we   = 1'b1;
            tick();
        end
        lut_we = 1'b0;
    endtask

    task automatic coef(input int c);
        apo_din = 16'(c);
        apo_we  = 1'b1;
        tick();
        apo_we  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; tx_en = 1'b1; start = 1'b0; ch_in = '0;
        apo_din = '0; apo_we = 1'b0;
        lut_addr = '0; lut_din = '0; lut_we = 1'b0;
        tick(); tick();
        chk("rst_dbf", dbf_dout, 0);
        chk("rst_dbf_v", dbf_dout_valid, 0);
        chk("rst_cd", cd_dout, 0);
        chk("rst_cd_v", cd_dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", line_done, 0);
        chk("rst_err", lut_wr_err, 0);
        rst_n = 1'b1;
        tick();

        lut_set(3, 1'b0);
        coef(16384);
        for (int v = 0; v < 10; v++) send(v, 1'b0);
        chk("idle_no_cd_v", cd_dout_valid, 0);
        chk("idle_busy", busy, 0);
        vcnt = 0;
        send(10, 1'b1);
        chk("d3_cd0", cd_dout, 7);
        chk("d3_cd0_v", cd_dout_valid, 1);
        chk("run_busy", busy, 1);
        send(11, 1'b0);
        chk("d3_cd1", cd_dout, 8);
        chk("lat_dbf_v0", dbf_dout_valid, 0);
        send(12, 1'b0);
        chk("rnd_7", dbf_dout, 4);
        chk("rnd_7_v", dbf_dout_valid, 1);
        send(13, 1'b0);
        chk("rnd_8", dbf_dout, 4);
        idle(1);
        chk("rnd_9_half", dbf_dout, 5);
        chk("pause_cd_v", cd_dout_valid, 0);
        idle(4);
        chk("pause_dbf_v", dbf_dout_valid, 0);
        chk("hold_dbf", dbf_dout, 5);
        chk("hold_cd", cd_dout, 10);
        chk("pause_busy", busy, 1);
        for (int v = 14; v < 26; v++) begin
            send(v, 1'b0);
            chk("d3_ramp", cd_dout, v - 3);
        end
        chk("end_done", line_done, 1);
        chk("end_busy", busy, 0);
        idle(1);
        chk("done_pulse", line_done, 0);
        idle(2);
        chk("line_vcnt", vcnt, 16);
        chk("drain_dbf", dbf_dout, 11);

        lut_set(0, 1'b0);
        send(-3, 1'b1);
        chk("byp_neg_cd", cd_dout, -3);
        idle(2);
        chk("rnd_neg3", dbf_dout, -1);
        coef(32767);
        send(1000, 1'b0);
        chk("byp_1000_cd", cd_dout, 1000);
        idle(2);
        chk("unity_1000", dbf_dout, 1000);
        coef(-32768);
        send(-8192, 1'b0);
        chk("byp_min_cd", cd_dout, -8192);
        idle(2);
        chk("neg_unity", dbf_dout, 8192);

        lut_addr = 4'd5; lut_din = 7'd99; lut_we = 1'b1;
        tick();
        lut_we = 1'b0;
        chk("lut_err_pulse", lut_wr_err, 1);
        tick();
        chk("lut_err_clear", lut_wr_err, 0);
        send(20, 1'b0);
        send(21, 1'b0);
        send(77, 1'b0);
        chk("lut_protect", cd_dout, 77);

        send(30, 1'b1);
        for (int k = 1; k < 15; k++) send(30 + k, 1'b0);
        chk("restart_busy", busy, 1);
        chk("restart_nodone", line_done, 0);
        send(45, 1'b0);
        chk("restart_done", line_done, 1);

        lut_set(5, 1'b0);
        send(100, 1'b1);
        for (int v = 101; v < 105; v++) send(v, 1'b0);
        rst_n = 1'b0; tx_en = 1'b0; ch_in = 14'd200;
        tick();
        chk("mrst_cd", cd_dout, 0);
        chk("mrst_cd_v", cd_dout_valid, 0);
        chk("mrst_dbf", dbf_dout, 0);
        chk("mrst_dbf_v", dbf_dout_valid, 0);
        chk("mrst_busy", busy, 0);
        rst_n = 1'b1; tx_en = 1'b1;
        tick();
        chk("mrst_nodone", line_done, 0);

        for (int j = 0; j < 16; j++) begin
            send(500 + j, j == 0);
            if (j < 5) chk("fill_mask", cd_dout, 0);
            else chk("fill_d5", cd_dout, 495 + j);
        end
        chk("fill_done", line_done, 1);
        for (int j = 16; j < 150; j++) send(500 + j, 1'b0);
        chk("prefill_cd_v", cd_dout_valid, 0);

        lut_set(0, 1'b1);
        for (int j = 150; j < 166; j++) begin
            send(500 + j, j == 150);
            chk("dyn_const", cd_dout, 650);
        end
        chk("dyn_done", line_done, 1);

        lut_set(127, 1'b0);
        send(666, 1'b1);
        chk("max_dly", cd_dout, 539);
        send(667, 1'b0);
        chk("max_dly_wrap", cd_dout, 540);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dbf_ch_dyn.md
Name: dbf_ch_dyn

Overview:
Parametrised single-channel digital beamforming front end with dynamic receive focusing. Each accepted sample is written into a circular coarse-delay buffer. The sample x[n-d] is read back, where d comes from a per-sample focusing delay LUT indexed by the sample count since start. That sample is then apodised by a loadable coefficient with round/saturate. One instance per receive channel feeds the beamformer summation tree.

Parameters:
INPUT_WD, 14, input sample width (signed)
APO_WD, 16, apodisation coefficient width (signed)
APO_FRAC, 15, fractional bits of the coefficient
ADDR_WD, 10, LUT address width; line length = 2^ADDR_WD samples
DLY_WD, 7, delay width; ring depth 2^DLY_WD, max delay 2^DLY_WD-1
OUT_WD, 32, output width (signed)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
tx_en  in  1  transmit active; sample accepted when tx_en==0
start  in  1  one-cycle pulse, begins a receive line
ch_in  in  INPUT_WD  signed input sample
apo_din  in  APO_WD  signed apodisation coefficient
apo_we  in  1  load apo_din into coefficient register
lut_addr  in  ADDR_WD  delay LUT write address
lut_din  in  DLY_WD  delay LUT write data (samples)
lut_we  in  1  delay LUT write enable
dbf_dout  out  OUT_WD  apodised delayed sample
dbf_dout_valid  out  1  dbf_dout qualifier
cd_dout  out  INPUT_WD  coarse-delayed sample (debug)
cd_dout_valid  out  1  cd_dout qualifier
busy  out  1  high in RUN
line_done  out  1  one-cycle pulse at end of line
lut_wr_err  out  1  one-cycle pulse: LUT write attempted in RUN (ignored)

Behaviour:
- Reset: synchronous, clk-sampled, rst_n==0. State=IDLE; wr_ptr, idx, fill counter and pipeline valids cleared; all outputs 0; coefficient register 0. LUT and ring RAM contents are not cleared. Reset mid-RUN aborts the line with no line_done.
- Accept: tx_en==0 on a clk edge, in any state. The sample is written to ring[wr_ptr], wr_ptr increments mod 2^DLY_WD, and fill increments, saturating at 2^DLY_WD-1.
- LUT and ring: distributed RAM, asynchronous read, synchronous write. LUT writes are performed only in IDLE. lut_we in RUN does not write and pulses lut_wr_err next cycle.
- Coefficient: apo_we loads apo_din in any state. The new value is used for products formed on following edges.
- FSM IDLE: start -> RUN with idx=0.
- FSM RUN:
  - Each accepted sample uses d=lut[idx]; idx increments.
  - Accepted sample with idx==2^ADDR_WD-1 -> IDLE, line_done pulses next cycle.
  - start during RUN restarts the line (idx=0).
  - tx_en==1 pauses acceptance without leaving RUN.
- Delay read (stage 1, same edge as accept, RUN only):
  - d==0: ch_in is bypassed directly.
  - d>fill: 0 is emitted (unwritten history).
  - Otherwise ring[wr_ptr-d] mod depth, equal to x[n-d].
  - The result is registered into cd_dout, with cd_dout_valid=1.
- Stage 2: prod = cd_dout * coef, signed, INPUT_WD+APO_WD bits.
- Stage 3:
  - r = (prod + 2^(APO_FRAC-1)) >>> APO_FRAC, i.e. round half toward +inf.
  - r is sign-extended to OUT_WD if narrower, else saturated to [-2^(OUT_WD-1), 2^(OUT_WD-1)-1].
  - r is registered into dbf_dout with dbf_dout_valid=1.
- Latency: sample accepted at edge k gives cd_dout after k, dbf_dout after k+2. Throughput is 1 sample/clk.
- Output hold: valids are 0 on cycles with no sample in that stage. The data outputs hold their last value.
- Drain: samples accepted in RUN complete the pipeline after the return to IDLE.
- No output in IDLE: accepts in IDLE only fill the ring and produce no output.
- busy is 1 exactly while in RUN.

Test Plan:
1. Constant delay/round: LUT all 3, coef 16384 (0.5), ramp ch_in=0,1,2..., 10 samples, then start -> cd_dout=x[n-3]. For x=7, dbf_dout=4. For ch_in=-3, coef 16384, d=0, dbf_dout=-1. Latency 2 edges after cd_dout's edge.
2. Bypass/near-unity: LUT all 0, coef 32767, ch_in=1000 -> cd_dout=1000 on the accept edge, dbf_dout=1000. ch_in=-8192, coef -32768 -> dbf_dout=8192.
3. Fill masking: reset, LUT all 5, start together with the first sample -> outputs 1-5 are 0, output 6 = first sample. Max delay 127 with a full ring returns x[n-127].
4. Dynamic delay/wrap: lut[i]=i mod 128, ADDR_WD=8, ramp input with ring pre-filled -> cd_dout constant for i<128 (x[n-i]). Pointer wrap past 127 gives no glitch.
5. Line end/LUT protect: ADDR_WD=4 -> line_done one cycle after the 16th accepted sample, busy falls, 16 dbf_dout_valid pulses. lut_we in RUN -> lut_wr_err pulse, entry unchanged on readback.
6. Pause/restart/reset: tx_en=1 for 5 cycles in RUN -> no valids, idx frozen. start mid-line -> idx back to 0. rst_n low mid-line -> all outputs 0 next edge, no line_done, LUT contents intact.
